bht_update_queue: RTL

Producer-side companion to the branch history table: collects resolved-branch outcomes from the execute stage and issues them as `bht_update_t` writes, at most one per cycle. Up to `NR_PORTS` branches resolve per cycle, so outcomes are buffered in a circular FIFO and drained in order. The block also filters out non-conditional branches, suppresses enqueue in debug mode, drops on overflow (with a counter), and empties on pipeline flush.

---
 rtl/bht_update_queue.sv | 104 ++++++++++
 1 files changed

// File: rtl/bht_update_queue.sv
// bht_update_queue: buffers resolved conditional-branch outcomes and drains them to the BHT, one per cycle
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   flush_i              discard queued and incoming entries
//   debug_mode_i         block enqueue while in debug mode
//   resolve_valid_i      per-port branch resolved
//   resolve_pc_i         per-port 64-bit PC, port p at [p*64 +: 64]
//   resolve_is_cond_i    per-port conditional-branch flag
//   resolve_taken_i      per-port actual direction
//   bht_update_o         {valid, pc[63:0], taken} to the BHT
//   count_o, full_o      registered occupancy and full flag
//   drop_cnt_o           saturating count of candidates lost to overflow
module bht_update_queue #(
    parameter int DEPTH    = 8,
    parameter int NR_PORTS = 2,
    parameter int CNT_W    = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     debug_mode_i,
    input  logic [NR_PORTS-1:0]      resolve_valid_i,
    input  logic [NR_PORTS*64-1:0]   resolve_pc_i,
    input  logic [NR_PORTS-1:0]      resolve_is_cond_i,
    input  logic [NR_PORTS-1:0]      resolve_taken_i,
    output logic [65:0]              bht_update_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic [CNT_W-1:0]         drop_cnt_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = (CNT_W > CW ? CNT_W : CW) + 1;
    localparam logic [CNT_W-1:0] MAX_DROP = '1;

    logic [PW-1:0]     r_head, r_tail;
    logic [CW-1:0]     r_count;
    logic [CNT_W-1:0]  r_drop;
    logic [63:0]       r_pc [DEPTH];
    logic              r_taken [DEPTH];

    logic              w_pop;
    logic [CW-1:0]     w_free, w_acc, w_drop;
    logic [NR_PORTS-1:0] w_we;
    logic [PW-1:0]     w_widx [NR_PORTS];
    logic [SW-1:0]     w_sum;

    assign w_pop  = (r_count != '0) && !flush_i;
    // a slot vacated by this cycle's pop is refillable in the same cycle
    assign w_free = CW'(DEPTH) - r_count + CW'(w_pop);

    // accepted candidates are packed in ascending port order, so higher ports drop first
    always_comb begin
        w_acc  = '0;
        w_drop = '0;
        w_we   = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            w_widx[p] = r_tail + w_acc[PW-1:0];
            if (resolve_valid_i[p] && resolve_is_cond_i[p] && !debug_mode_i && !flush_i) begin
                if (w_acc < w_free) begin
                    w_we[p] = 1'b1;
                    w_acc   = w_acc + CW'(1);
                end else begin
                    w_drop  = w_drop + CW'(1);
                end
            end
        end
    end

    // widened add so the saturation test cannot itself overflow
    assign w_sum = SW'(r_drop) + SW'(w_drop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_drop  <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_pop);
            r_tail  <= r_tail + w_acc[PW-1:0];
            r_count <= r_count + w_acc - CW'(w_pop);
            r_drop  <= (w_sum > SW'(MAX_DROP)) ? MAX_DROP : w_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NR_PORTS; p++) begin
            if (w_we[p]) begin
                r_pc[w_widx[p]]    <= resolve_pc_i[p*64 +: 64];
                r_taken[w_widx[p]] <= resolve_taken_i[p];
            end
        end
    end

    assign bht_update_o = {w_pop, r_pc[r_head], r_taken[r_head]};
    assign count_o      = r_count;
    assign full_o       = r_count == CW'(DEPTH);
    assign drop_cnt_o   = r_drop;
endmodule
